max7219_cmd_seq: RTL

//  Command sequencer directly upstream of the MAX7219 SPI serializer. After reset it issues the
//  MAX7219 init writes. It then pushes 8-digit display frames as 16-bit (addr,data) register

---
 rtl/max7219_pkg.sv | 33 +++
 rtl/max7219_refresh_timer.sv | 25 ++
 rtl/max7219_cmd_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - shared MAX7219 register map, sequencer state and command types
package max7219_pkg;

    localparam logic [7:0] REG_NOP       = 8'h00;
    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCAN      = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    typedef enum logic [1:0] {INIT, IDLE, FRAME, INTEN} seq_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } max7219_cmd_t;

    // Power-up register writes: test off, shutdown off, scan limit, intensity, decode mode.
    function automatic max7219_cmd_t init_cmd(input logic [2:0] idx, input logic [2:0] scan,
                                              input logic [7:0] decode, input logic [3:0] inten);
        max7219_cmd_t c;
        case (idx)
            3'd0:    c = '{addr: REG_TEST,      data: 8'h00};
            3'd1:    c = '{addr: REG_SHUTDOWN,  data: 8'h01};
            3'd2:    c = '{addr: REG_SCAN,      data: {5'b0, scan}};
            3'd3:    c = '{addr: REG_INTENSITY, data: {4'b0, inten}};
            default: c = '{addr: REG_DECODE,    data: decode};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/max7219_refresh_timer.sv
// rtl/max7219_refresh_timer.sv - idle refresh down-counter with load, enable and expired flag
module max7219_refresh_timer #(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] RELOAD = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || load) begin
            count <= RELOAD;
        end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/max7219_cmd_seq.sv
// rtl/max7219_cmd_seq.sv - MAX7219 init, frame and intensity command sequencer
module max7219_cmd_seq
    import max7219_pkg::*;
#(
    parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
    parameter logic [7:0]  DECODE_MODE    = 8'hFF,
    parameter logic [3:0]  INIT_INTENSITY = 4'hF,
    parameter int unsigned REFRESH_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        update,
    input  logic [63:0] digit_data,
    input  logic [3:0]  intensity,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    input  logic        cmd_ready,
    output logic        init_done,
    output logic        busy,
    output logic        frame_done
);

    seq_state_t   state;
    logic [2:0]   idx;
    logic [2:0]   nidx;
    max7219_cmd_t cmd;
    logic [3:0]   int_shadow;
    logic [63:0]  staging;
    logic [63:0]  frame_buf;
    logic         pend;
    logic         xfer;
    logic         start_frame;
    logic         refresh_expired;

    assign xfer     = cmd_valid && cmd_ready;
    assign nidx     = idx + 3'd1;
    assign cmd_addr = cmd.addr;
    assign cmd_data = cmd.data;
    assign busy     = (state != IDLE);

    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
            max7219_refresh_timer #(
                .WIDTH (RW),
                .RELOAD(RW'(REFRESH_CYCLES - 1))
            ) u_timer (
                .clk    (clk),
                .reset_n(reset_n),
                .load   (state != IDLE),
                .enable (state == IDLE),
                .expired(refresh_expired)
            );
        end else begin : g_no_refresh
            assign refresh_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        start_frame = 1'b0;
        if (state == INIT && xfer && idx == 3'd4) begin
            start_frame = 1'b1;
        end else if (state == IDLE) begin
            start_frame = pend || (intensity == int_shadow && refresh_expired);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= INIT;
            idx        <= 3'd0;
            cmd_valid  <= 1'b0;
            cmd        <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            pend       <= 1'b0;
            staging    <= '0;
            frame_buf  <= '0;
            int_shadow <= INIT_INTENSITY;
        end else begin
            frame_done <= 1'b0;
            case (state)
                INIT: begin
                    if (!cmd_valid) begin
                        cmd_valid <= 1'b1;
                        cmd       <= init_cmd(idx, SCAN_LIMIT, DECODE_MODE, INIT_INTENSITY);
                    end else if (cmd_ready) begin
                        if (idx == 3'd3) int_shadow <= INIT_INTENSITY;
                        if (idx == 3'd4) begin
                            init_done <= 1'b1;
                        end else begin
                            idx <= nidx;
                            cmd <= init_cmd(nidx, SCAN_LIMIT, DECODE_MODE, INIT_INTENSITY);
                        end
                    end
                end
                IDLE: begin
                    if (!pend && intensity != int_shadow) begin
                        state     <= INTEN;
                        cmd_valid <= 1'b1;
                        cmd       <= '{addr: REG_INTENSITY, data: {4'b0, intensity}};
                    end
                end
                FRAME: begin
                    if (xfer) begin
                        if (idx == 3'd7) begin
                            frame_done <= 1'b1;
                            cmd_valid  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx <= nidx;
                            cmd <= '{addr: REG_DIGIT0 + {5'b0, nidx},
                                     data: frame_buf[{nidx, 3'b000} +: 8]};
                        end
                    end
                end
                INTEN: begin
                    // Shadow what was actually written so a later change triggers another write.
                    if (xfer) begin
                        int_shadow <= cmd.data[3:0];
                        cmd_valid  <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase

            // Frame buffer only reloads here, so a frame in flight is never torn.
            if (start_frame) begin
                state     <= FRAME;
                idx       <= 3'd0;
                frame_buf <= staging;
                pend      <= 1'b0;
                cmd_valid <= 1'b1;
                cmd       <= '{addr: REG_DIGIT0, data: staging[7:0]};
            end

            if (update) begin
                staging <= digit_data;
                pend    <= 1'b1;
            end
        end
    end

endmodule
